// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with registered result and valid/ready handshake.
//   Single-cycle ops: add, sub, and, or, xor, slt, sltu, sll, srl, sra.
//   Iterative ops (one result bit per cycle over WIDTH cycles): mul, mulhu, divu, remu.
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   flush               synchronous abort of any in-flight or held op
//   in_valid/in_ready   op handshake; ALUControlE, Op1E, Op2E sampled on acceptance
//   out_valid/out_ready result handshake; ALUResultE, Flags {N,Z,C,V}, ZeroE
//   BusyE               iterative op in progress
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControlE,
    input  logic [WIDTH-1:0] Op1E,
    input  logic [WIDTH-1:0] Op2E,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResultE,
    output logic [3:0]       Flags,
    output logic             ZeroE,
    output logic             BusyE
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_n;
    logic             accept, iter_op;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, qr, b_q;   // mul: {acc,qr} = partial product; div: acc = remainder, qr = quotient
    logic             div_q, hi_q;    // op kind of the iterative op in flight
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    // ---------------- single-cycle datapath ----------------
    logic             is_sub;
    logic [WIDTH-1:0] b_eff, fres;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic             fc, fv;
    logic [3:0]       fflags;

    always_comb begin
        is_sub = (ALUControlE == 4'h1);
        // add and sub share one carry chain: sub = a + ~b + 1
        b_eff  = is_sub ? ~Op2E : Op2E;
        sum    = {1'b0, Op1E} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        shamt  = Op2E[SHW-1:0];
        fres   = '0;
        fc     = 1'b0;
        fv     = 1'b0;
        case (ALUControlE)
            4'h0, 4'h1: begin
                fres = sum[WIDTH-1:0];
                fc   = sum[WIDTH];
                // overflow when both addends share a sign the result does not
                fv   = (Op1E[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != Op1E[WIDTH-1]);
            end
            4'h2:    fres = Op1E & Op2E;
            4'h3:    fres = Op1E | Op2E;
            4'h4:    fres = Op1E ^ Op2E;
            4'h5:    fres = {{(WIDTH-1){1'b0}}, ($signed(Op1E) < $signed(Op2E))};
            4'h6:    fres = {{(WIDTH-1){1'b0}}, (Op1E < Op2E)};
            4'h7:    fres = Op1E << shamt;
            4'h8:    fres = Op1E >> shamt;
            4'h9:    fres = $signed(Op1E) >>> shamt;
            default: fres = '0;   // reserved and disabled mul/div opcodes
        endcase
        fflags = {fres[WIDTH-1], (fres == '0), fc, fv};
        if (ALUControlE[3:1] == 3'b111)
            fflags = 4'b0000;
    end

    assign iter_op = (MUL_EN && (ALUControlE == 4'hA || ALUControlE == 4'hB)) ||
                     (DIV_EN && (ALUControlE == 4'hC || ALUControlE == 4'hD));

    // ---------------- iterative step ----------------
    logic [WIDTH:0]   mul_sum, r_sh;
    logic [WIDTH-1:0] r_sub, acc_n, qr_n, step_res;
    logic             ge, last;

    always_comb begin
        mul_sum = {1'b0, acc} + (qr[0] ? {1'b0, b_q} : '0);
        // restoring divide: shift next dividend bit into remainder, subtract if it fits
        r_sh    = {acc, qr[WIDTH-1]};
        ge      = (r_sh >= {1'b0, b_q});
        r_sub   = r_sh[WIDTH-1:0] - b_q;
        if (div_q) begin
            acc_n = ge ? r_sub : r_sh[WIDTH-1:0];
            qr_n  = {qr[WIDTH-2:0], ge};
        end else begin
            acc_n = mul_sum[WIDTH:1];
            qr_n  = {mul_sum[0], qr[WIDTH-1:1]};
        end
        step_res = hi_q ? acc_n : qr_n;
        last     = (cnt == CW'(WIDTH - 1));
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        case (state)
            IDLE: in_ready = !flush;
            DONE: in_ready = out_ready && !flush;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
        case (state)
            IDLE: if (accept) state_n = iter_op ? BUSY : DONE;
            BUSY: if (last)   state_n = DONE;
            DONE: if (out_ready) state_n = accept ? (iter_op ? BUSY : DONE) : IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            acc      <= '0;
            qr       <= '0;
            b_q      <= '0;
            div_q    <= 1'b0;
            hi_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (flush) begin
            cnt      <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (accept) begin
            if (iter_op) begin
                acc   <= '0;
                qr    <= Op1E;
                b_q   <= Op2E;
                div_q <= ALUControlE[2];
                hi_q  <= ALUControlE[0];
                cnt   <= '0;
            end else begin
                result_q <= fres;
                flags_q  <= fflags;
            end
        end else if (state == BUSY) begin
            acc <= acc_n;
            qr  <= qr_n;
            cnt <= cnt + CW'(1);
            if (last) begin
                result_q <= step_res;
                flags_q  <= {step_res[WIDTH-1], (step_res == '0), 2'b00};
            end
        end
    end

    assign out_valid  = (state == DONE);
    assign BusyE      = (state == BUSY);
    assign ALUResultE = result_q;
    assign Flags      = flags_q;
    assign ZeroE      = (result_q == '0);
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_n, flush, in_valid, out_ready;
    logic [3:0]    ALUControlE;
    logic [W-1:0]  Op1E, Op2E;
    logic          in_ready, out_valid, ZeroE, BusyE;
    logic [W-1:0]  ALUResultE;
    logic [3:0]    Flags;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUControlE(ALUControlE), .Op1E(Op1E), .Op2E(Op2E),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResultE(ALUResultE), .Flags(Flags), .ZeroE(ZeroE), .BusyE(BusyE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, res;
        logic [3:0]   flg;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        int           exp_cyc;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0, errors = 0;
    int  busy_viol = 0;
    bit  seen = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one op; waits (bounded) for in_ready, then pushes the expected result.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic [3:0] flg, input bit set_rdy,
                         output int waited);
        int lat;
        @(negedge clk);
        if (set_rdy) out_ready = 1'b1;
        in_valid = 1'b1; ALUControlE = op; Op1E = a; Op2E = b;
        #1;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk); #1; waited++;
        end
        if (waited >= 200) begin
            chk("accept_timeout", 32'(waited), 32'd0);
        end else begin
            lat = (op >= 4'hA && op <= 4'hD) ? W + 1 : 1;
            sbq.push_back('{res: res, flg: flg, exp_cyc: cyc + lat});
            @(posedge clk);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (sbq.size() != 0 && g < 300) begin
            @(negedge clk); g++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic count_out(input int n, output int hits);
        hits = 0;
        repeat (n) begin
            @(negedge clk); #1;
            if (out_valid) hits++;
        end
    endtask

    // Scoreboard monitor: checks first-valid latency and the handshaked result.
    initial begin
        forever begin
            @(negedge clk); #1;
            if (reset_n) begin
                if (BusyE && (in_ready || out_valid)) busy_viol++;
                if (sbq.size() == 0) seen = 0;
                if (out_valid) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        if (!seen) begin
                            chk("latency", 32'(cyc), 32'(sbq[0].exp_cyc));
                            seen = 1;
                        end
                        if (out_ready) begin
                            chk("result", ALUResultE, sbq[0].res);
                            chk("flags", 32'(Flags), 32'(sbq[0].flg));
                            chk("zero", 32'(ZeroE), 32'(sbq[0].res == '0));
                            void'(sbq.pop_front());
                            seen = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[21];
        int   w, hits;
        vt[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
        vt[1]  = '{4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
        vt[2]  = '{4'h1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000};
        vt[3]  = '{4'h2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000};
        vt[4]  = '{4'h3, 32'h00000001, 32'h80000000, 32'h80000001, 4'b1000};
        vt[5]  = '{4'h4, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 4'b0000};
        vt[6]  = '{4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000};
        vt[7]  = '{4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100};
        vt[8]  = '{4'h7, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 4'b1000};
        vt[9]  = '{4'h8, 32'h80000000, 32'h00000004, 32'h08000000, 4'b0000};
        vt[10] = '{4'h9, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b1000};
        vt[11] = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
        vt[12] = '{4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
        vt[13] = '{4'hA, 32'h00010001, 32'h00010001, 32'h00020001, 4'b0000};
        vt[14] = '{4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000};
        vt[15] = '{4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000};
        vt[16] = '{4'hC, 32'd100,      32'd7,        32'd14,       4'b0000};
        vt[17] = '{4'hD, 32'd100,      32'd7,        32'd2,        4'b0000};
        vt[18] = '{4'hC, 32'd9,        32'd0,        32'hFFFFFFFF, 4'b1000};
        vt[19] = '{4'hD, 32'd9,        32'd0,        32'd9,        4'b0000};
        vt[20] = '{4'hE, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0000};

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ALUControlE = '0; Op1E = '0; Op2E = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", ALUResultE, 32'd0);
        chk("rst_flags", 32'(Flags), 32'd0);
        chk("rst_zero", 32'(ZeroE), 32'd1);
        chk("rst_busy", 32'(BusyE), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // table: issued back to back, consumer always ready
        for (int i = 0; i < 21; i++)
            issue(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].flg, 1'b0, w);
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // held result: out_ready low for 5 cycles, then take it together with a new add
        @(negedge clk);
        out_ready = 1'b0;
        issue(4'h4, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 4'b1000, 1'b0, w);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", ALUResultE, 32'hAAAAAAAA);
            chk("hold_flags", 32'(Flags), 32'h8);
            if (k < 4) @(negedge clk);
        end
        issue(4'h0, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b1, w);
        chk("no_bubble_wait", 32'(w), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // flush at busy cycle 10 of a divu
        issue(4'hC, 32'd100, 32'd7, 32'd14, 4'b0000, 1'b0, w);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        chk("pre_flush_busy", 32'(BusyE), 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        sbq.delete();
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(BusyE), 32'd0);
        chk("flush_idle_ready", 32'(in_ready), 32'd1);
        count_out(W + 5, hits);
        chk("flush_no_out", 32'(hits), 32'd0);

        // async reset in the middle of a multiply
        issue(4'hA, 32'd3, 32'd4, 32'd12, 4'b0000, 1'b0, w);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        sbq.delete();
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(BusyE), 32'd0);
        chk("arst_result", ALUResultE, 32'd0);
        chk("arst_flags", 32'(Flags), 32'd0);
        chk("arst_zero", 32'(ZeroE), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("arst_idle_ready", 32'(in_ready), 32'd1);
        count_out(W + 5, hits);
        chk("arst_no_out", 32'(hits), 32'd0);

        chk("busy_handshake_excl", 32'(busy_viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
